// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the quad-capable SPI slave.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    STD     = 2'd0,
    QUAD_TX = 2'd1,
    QUAD_RX = 2'd2
  } spi_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam logic [3:0] OE_NONE = 4'b0000;
  localparam logic [3:0] OE_STD  = 4'b0010;
  localparam logic [3:0] OE_QUAD = 4'b1111;

  // Reserved encoding 3 collapses onto STD.
  function automatic spi_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return QUAD_TX;
      2'd2:    return QUAD_RX;
      default: return STD;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// N-flop synchroniser with rise/fall edge detection on the synchronised value.
module spi_slave_sync #(
  parameter int unsigned     STAGES  = 2,
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  // Shift the input through the synchroniser chain and keep the previous output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;
  assign fall = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_quad.sv
// SPI mode-0 slave with standard, quad-TX and quad-RX transfers.
module spi_slave_quad
  import spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_i,
  input  logic       spi_sclk_i,
  input  logic       spi_csn_i,
  input  logic [3:0] spi_sdi_i,
  output logic [3:0] spi_sdo_o,
  output logic [3:0] spi_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       underrun_o,
  output logic       frame_end_o,
  output logic       partial_o,
  output logic       busy_o
);

  logic       sclk_q_unused, sclk_rise, sclk_fall;
  logic       csn_q_unused, csn_rise, csn_fall;
  logic [3:0] sdi_q, sdi_rise_unused, sdi_fall_unused;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk_i),
    .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // Resetting the CSn chain low means a CSn already low at reset release is
  // not seen as a fall; a fresh high/low cycle is needed to start a frame.
  spi_slave_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_csn (
    .clk(clk), .rst_n(rst_n), .d(spi_csn_i),
    .q(csn_q_unused), .rise(csn_rise), .fall(csn_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .WIDTH(4), .RST_VAL(4'h0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(spi_sdi_i),
    .q(sdi_q), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  state_e     state;
  spi_mode_e  mode_q;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic [2:0] cnt;
  logic       byte_done;

  logic       is_quad;
  logic       rx_edge;
  logic       final_edge;
  logic [2:0] last_cnt;
  logic [2:0] cnt_after;
  logic [7:0] rx_next;

  // Per-edge bookkeeping: where the edge counter lands after this cycle.
  always_comb begin
    is_quad    = (mode_q != STD);
    last_cnt   = is_quad ? 3'd1 : 3'd7;
    rx_edge    = (state == SHIFT) && sclk_rise;
    final_edge = rx_edge && (cnt == last_cnt);
    rx_next    = is_quad ? {rx_sh[3:0], sdi_q} : {rx_sh[6:0], sdi_q[0]};
    if (final_edge)   cnt_after = '0;
    else if (rx_edge) cnt_after = cnt + 3'd1;
    else              cnt_after = cnt;
  end

  // Pad drive follows the latched mode whenever a frame is active.
  always_comb begin
    spi_sdo_o = '0;
    spi_oe_o  = OE_NONE;
    if (state != IDLE) begin
      case (mode_q)
        QUAD_RX: begin
          spi_oe_o  = OE_QUAD;
          spi_sdo_o = tx_sh[7:4];
        end
        QUAD_TX: spi_oe_o = OE_NONE;
        default: begin
          spi_oe_o     = OE_STD;
          spi_sdo_o[1] = tx_sh[7];
        end
      endcase
    end
  end

  assign tx_ready_o = (state == LOAD) && tx_valid_i;
  assign underrun_o = (state == LOAD) && !tx_valid_i;
  assign busy_o     = (state != IDLE);

  // Frame FSM, shift registers and strobes; CSn rise overrides the state last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= STD;
      tx_sh       <= '0;
      rx_sh       <= '0;
      cnt         <= '0;
      byte_done   <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_end_o <= 1'b0;
      partial_o   <= 1'b0;
    end else begin
      rx_valid_o  <= 1'b0;
      frame_end_o <= 1'b0;
      partial_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (csn_fall) begin
            state     <= LOAD;
            mode_q    <= decode_mode(mode_i);
            cnt       <= '0;
            byte_done <= 1'b0;
          end
        end
        LOAD: begin
          tx_sh     <= tx_valid_i ? tx_data_i : FILL_BYTE;
          byte_done <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (rx_edge) begin
            cnt <= cnt_after;
            if (mode_q != QUAD_RX) rx_sh <= rx_next;
            if (final_edge) begin
              byte_done <= 1'b1;
              if (mode_q != QUAD_RX) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            if (byte_done) state <= LOAD;
            else           tx_sh <= is_quad ? {tx_sh[3:0], 4'h0} : {tx_sh[6:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
      // A final rise coinciding with CSn rise completes the byte (cnt_after == 0).
      if ((state != IDLE) && csn_rise) begin
        state       <= IDLE;
        frame_end_o <= 1'b1;
        partial_o   <= (cnt_after != '0);
        cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_quad.sv
// Scoreboarded bench: an SPI master model drives frames, a TX source feeds bytes.
module tb_spi_slave_quad;

  localparam logic [7:0] FILL = 8'hFF;
  localparam time        HP   = 80ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic       sclk = 1'b0;
  logic       csn = 1'b1;
  logic [3:0] sdi = 4'h0;
  logic [3:0] sdo, oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, underrun, frame_end, partial, busy;

  spi_slave_quad #(.SYNC_STAGES(2), .FILL_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .spi_sclk_i(sclk), .spi_csn_i(csn), .spi_sdi_i(sdi),
    .spi_sdo_o(sdo), .spi_oe_o(oe),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .underrun_o(underrun), .frame_end_o(frame_end), .partial_o(partial),
    .busy_o(busy)
  );

  always #5ns clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_exp[$];
  logic       fe_exp[$];
  logic [7:0] txq[$];
  logic [7:0] mosi[$];
  logic       tx_en = 1'b0;
  int         acc_cnt = 0;
  int         und_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // TX source: presents the head of txq while enabled, pops on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        void'(txq.pop_front());
      end
      if (underrun) und_cnt++;
      @(posedge clk);
      #1ns;
      tx_valid = tx_en && (txq.size() > 0);
      tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
    end
  end

  // Monitor: compares every RX strobe and frame end against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_exp.size() == 0) check("rx_unexpected_strobe", {31'b0, rx_valid}, 32'd0);
        else                    check("rx_data", {24'b0, rx_data}, {24'b0, rx_exp.pop_front()});
      end
      if (frame_end) begin
        if (fe_exp.size() == 0) check("frame_end_unexpected", {31'b0, frame_end}, 32'd0);
        else                    check("partial", {31'b0, partial}, {31'b0, fe_exp.pop_front()});
      end
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Master model. n_edges rising edges are issued; simul_end raises CSn together
  // with the last rising edge. The slave loads one byte at frame start and one
  // after every completed byte that is followed by a falling edge.
  task automatic run_frame(input logic [1:0] m, input int n_edges, input bit simul_end);
    int         epb, full, slots, avail, acc_exp, acc0, und0, b, k;
    bit         part;
    logic [7:0] snap[$];
    logic [7:0] cur, miso, exp_b;
    logic [3:0] exp_oe;
    epb   = (m == 2'd1 || m == 2'd2) ? 2 : 8;
    full  = n_edges / epb;
    part  = (n_edges % epb) != 0;
    slots = simul_end ? full : full + 1;
    snap  = txq;
    avail = tx_en ? txq.size() : 0;
    acc_exp = (slots < avail) ? slots : avail;
    exp_oe  = (m == 2'd2) ? 4'b1111 : (m == 2'd1) ? 4'b0000 : 4'b0010;
    if (m != 2'd2) for (int i = 0; i < full; i++) rx_exp.push_back(mosi[i]);
    fe_exp.push_back(part);
    acc0 = acc_cnt;
    und0 = und_cnt;
    miso = 8'h00;

    mode_i = m;
    csn = 1'b0;
    #100ns;
    mode_i = 2'($urandom);
    for (int e = 0; e < n_edges; e++) begin
      b   = e / epb;
      k   = e % epb;
      cur = mosi[b];
      if (epb == 8)       sdi = {3'($urandom), cur[7-k]};
      else if (m == 2'd1) sdi = (k == 0) ? cur[7:4] : cur[3:0];
      else                sdi = 4'($urandom);
      #HP;
      check("oe_in_frame", {28'b0, oe}, {28'b0, exp_oe});
      if (m == 2'd2)      miso = {miso[3:0], sdo};
      else if (m != 2'd1) miso = {miso[6:0], sdo[1]};
      if (simul_end && e == n_edges - 1) csn = 1'b1;
      sclk = 1'b1;
      if (k == epb - 1 && m != 2'd1) begin
        exp_b = (b < avail) ? snap[b] : FILL;
        check("miso_byte", {24'b0, miso}, {24'b0, exp_b});
      end
      #HP;
      if (!(simul_end && e == n_edges - 1)) sclk = 1'b0;
    end
    if (!simul_end) begin
      #(2*HP);
      csn = 1'b1;
    end
    #200ns;
    sclk = 1'b0;
    #200ns;
    check("oe_after_frame", {28'b0, oe}, 32'd0);
    check("busy_after_frame", {31'b0, busy}, 32'd0);
    check("tx_accepts", acc_cnt - acc0, acc_exp);
    check("underruns", und_cnt - und0, slots - acc_exp);
  endtask

  task automatic set_tx(input bit en, input int n);
    txq.delete();
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
    tx_en = en;
    #50ns;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sdo"}, {28'b0, sdo}, 32'd0);
    check({tag, "_oe"}, {28'b0, oe}, 32'd0);
    check({tag, "_rx_data"}, {24'b0, rx_data}, 32'd0);
    check({tag, "_ctrl"}, {26'b0, rx_valid, tx_ready, underrun, frame_end, partial, busy}, 32'd0);
  endtask

  initial begin
    int nb, ne;
    bit sim;
    #3ns;
    check_all_zero("reset");
    #30ns;
    rst_n = 1'b1;
    #200ns;

    // STD: receive 0xA5 while sending preloaded 0x3C.
    set_tx(1'b1, 0); txq.push_back(8'h3C);
    mosi.delete(); mosi.push_back(8'hA5);
    run_frame(2'd0, 8, 1'b0);

    // QUAD_TX: two bytes in one frame.
    set_tx(1'b1, 2);
    mosi.delete(); mosi.push_back(8'h12); mosi.push_back(8'h34);
    run_frame(2'd1, 4, 1'b0);

    // QUAD_RX: slave drives 0xDE, 0xAD.
    set_tx(1'b1, 0); txq.push_back(8'hDE); txq.push_back(8'hAD);
    mosi.delete(); mosi.push_back(8'h00); mosi.push_back(8'h00);
    run_frame(2'd2, 4, 1'b0);

    // STD with no TX data: fill bytes and underruns.
    set_tx(1'b0, 0);
    mosi.delete(); mosi.push_back(8'h5C); mosi.push_back(8'hE7);
    run_frame(2'd0, 16, 1'b0);

    // Frame cut after 5 bits, then a clean 0x81.
    set_tx(1'b1, 2);
    mosi.delete(); mosi.push_back(8'hF0);
    run_frame(2'd0, 5, 1'b0);
    mosi.delete(); mosi.push_back(8'h81);
    run_frame(2'd0, 8, 1'b0);

    // CSn rise together with the final rising edge, reserved mode.
    set_tx(1'b1, 1);
    mosi.delete(); mosi.push_back(8'hC3);
    run_frame(2'd3, 8, 1'b1);

    // Reset after 3 bits with CSn held low.
    set_tx(1'b1, 3);
    mosi.delete(); mosi.push_back(8'hFF);
    mode_i = 2'd0;
    csn = 1'b0;
    #100ns;
    for (int e = 0; e < 3; e++) begin
      sdi = 4'h1; #HP; sclk = 1'b1; #HP; sclk = 1'b0;
    end
    #HP;
    rst_n = 1'b0;
    #30ns;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    #400ns;
    check("busy_after_reset_csn_low", {31'b0, busy}, 32'd0);
    csn = 1'b1;
    #400ns;
    set_tx(1'b1, 2);
    mosi.delete(); mosi.push_back(8'h5A);
    run_frame(2'd0, 8, 1'b0);

    // Randomised frames.
    for (int r = 0; r < 14; r++) begin
      logic [1:0] m;
      m  = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 3);
      mosi.delete();
      for (int i = 0; i < nb + 1; i++) mosi.push_back(8'($urandom));
      ne  = nb * ((m == 2'd1 || m == 2'd2) ? 2 : 8);
      sim = 1'b0;
      if ($urandom_range(0, 3) == 0) ne = ne - $urandom_range(1, (m == 2'd1 || m == 2'd2) ? 1 : 7);
      else if ($urandom_range(0, 2) == 0) sim = 1'b1;
      set_tx(1'($urandom), $urandom_range(0, 4));
      run_frame(m, ne, sim);
    end

    #200ns;
    check("rx_scoreboard_drained", rx_exp.size(), 32'd0);
    check("frame_scoreboard_drained", fe_exp.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_quad.md
Name: spi_slave_quad

Overview:
- SPI slave, the responder for the quad-capable SPI master already in the SoC (std, quad-TX and quad-RX modes, mode 0: CPOL=0, CPHA=0).
- Oversamples the external SCLK, CSn and SDIO pins in the single system clock domain.
- Deframes the serial stream into bytes on a valid-only RX port.
- Serialises bytes taken from a valid/ready TX port.
- Used for board-to-board links and as the loopback partner for master verification; sits between the pad muxing and a peripheral FIFO/APB wrapper.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on sclk/csn/sdi inputs (minimum 2).
- FILL_BYTE, 8'hFF, byte shifted out when no TX data is available (underrun).

Ports:
- clk  in  1  system clock; SCLK must be at most clk/8.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  2  0=STD, 1=QUAD_TX (master drives 4 lines), 2=QUAD_RX (slave drives 4 lines), 3=reserved, treated as STD.
- spi_sclk_i  in  1  SPI clock from the master.
- spi_csn_i  in  1  chip select, active low.
- spi_sdi_i  in  4  pad input data lines.
- spi_sdo_o  out  4  pad output data lines.
- spi_oe_o  out  4  per-line output enable (1 = drive).
- rx_data_o  out  8  received byte.
- rx_valid_o  out  1  one-cycle strobe; rx_data_o is valid in that cycle.
- tx_data_i  in  8  byte to transmit.
- tx_valid_i  in  1  tx_data_i is available.
- tx_ready_o  out  1  one-cycle accept strobe; the byte is consumed when tx_valid_i & tx_ready_o.
- underrun_o  out  1  one-cycle pulse when FILL_BYTE is loaded in place of TX data.
- frame_end_o  out  1  one-cycle pulse on CSn deassert.
- partial_o  out  1  valid together with frame_end_o; 1 if a byte was cut short.
- busy_o  out  1  high while a frame is active.

Behaviour:
- Reset: all outputs 0; spi_sdo_o = 4'h0; spi_oe_o = 4'h0; FSM = IDLE; shift registers cleared.
- Synchronisation:
  - sclk, csn and sdi pass through SYNC_STAGES flops.
  - Edge detect on the synchronised sclk gives rise_p and fall_p.
  - A csn falling edge is detected on the synchronised csn.
- Mode latch:
  - mode_i is captured into mode_q on the detected CSn fall.
  - Changes to mode_i during a frame are ignored.
- Bits per edge:
  - bpe = 1 in STD; bpe = 4 in QUAD_TX and QUAD_RX.
  - The edge counter counts 8 (STD) or 2 (quad) edges per byte.
- FSM IDLE:
  - On CSn fall: go to LOAD and set busy_o = 1.
- FSM LOAD (1 cycle):
  - If tx_valid_i: pulse tx_ready_o and take tx_data_i into tx_sh.
  - Otherwise: load FILL_BYTE and pulse underrun_o.
  - Drive the MSB or MSB nibble immediately.
  - Go to SHIFT.
- FSM SHIFT, on rise_p:
  - STD: sample sdi[0], shifted in MSB first.
  - QUAD_TX: sample sdi[3:0], high nibble first.
  - QUAD_RX: the slave receives nothing; rx_sh is left unchanged and no rx_valid_o is produced.
  - On the last edge of a byte, in STD or QUAD_TX: rx_data_o <= assembled byte and rx_valid_o pulses in the following cycle.
- FSM SHIFT, on fall_p:
  - Advance tx_sh.
  - After the last edge of a byte, return to LOAD; the next byte is ready before the next rise.
- Output drive:
  - STD: spi_oe_o = 4'b0010, sdo[1] = tx bit.
  - QUAD_RX: spi_oe_o = 4'b1111, sdo[3:0] = tx nibble.
  - QUAD_TX: spi_oe_o = 4'b0000.
  - IDLE: spi_oe_o = 4'b0000.
- CSn rise (any state except IDLE):
  - Go to IDLE, release spi_oe_o and pulse frame_end_o.
  - partial_o = 1 if the edge counter is non-zero; the partial byte is discarded and there is no rx_valid_o.
  - A byte already accepted via tx_ready_o but not fully sent is dropped.
- Simultaneous events:
  - CSn rise in the same cycle as a final rise_p: the byte completes (rx_valid_o fires) and then the FSM goes to IDLE with partial_o = 0.
  - rx_valid_o and frame_end_o may be high in the same cycle.
- Reserved mode 3: handled exactly as STD.
- rst_n asserted mid-frame: immediate return to the reset state. After release, the FSM waits for a fresh CSn fall; if CSn is already low, nothing happens until CSn goes high and then low again.

Decomposition:
- Package spi_slave_pkg:
  - spi_mode_e {STD=0, QUAD_TX=1, QUAD_RX=2}.
  - state_e {IDLE, LOAD, SHIFT}.
  - Constants for the STD and QUAD OE masks.
- Sub-module spi_slave_sync:
  - Parameterised N-flop synchroniser plus edge detector.
  - One instance for sclk (rise/fall), one for csn, and a synchroniser for the 4 data lines.

Test Plan:
- STD, master sends 0xA5, tx_data 0x3C preloaded:
  - rx_valid_o once with rx_data_o = 0xA5.
  - sdo[1] serialises 0,0,1,1,1,1,0,0.
  - tx_ready_o pulses once; underrun_o = 0.
- QUAD_TX, master sends 0x12, 0x34 in one frame:
  - Two rx_valid_o strobes, with 0x12 then 0x34.
  - spi_oe_o stays 0000.
  - frame_end_o with partial_o = 0.
- QUAD_RX, tx_valid_i held with 0xDE then 0xAD:
  - Lines carry nibbles D, E, A, D.
  - spi_oe_o = 1111 during the frame and 0000 after CSn rise.
- STD, tx_valid_i = 0:
  - FILL 0xFF is shifted out.
  - underrun_o pulses at each byte start.
- CSn raised after 5 bits in STD:
  - No rx_valid_o.
  - frame_end_o = 1 and partial_o = 1.
  - The next frame receives 0x81 correctly.
- rst_n pulsed low after 3 bits with CSn still low:
  - All outputs 0 and no rx_valid_o.
  - After a CSn high/low cycle, the byte 0x5A is received correctly.
